// File: rtl/sprite_blit.sv
// Sprite blitter: walks an SPR_WIDTH x SPR_HEIGHT bitmap from a synchronous ROM
// and writes every visible, non-transparent pixel into the framebuffer.
module sprite_blit #(
  parameter int CORDW      = 16,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int SPR_WIDTH  = 8,
  parameter int SPR_HEIGHT = 8,
  parameter int SPR_DATAW  = 4,
  parameter int TRANS_IDX  = 0,
  parameter int FB_ADDRW   = 19,
  localparam int SPR_ADDRW = (SPR_WIDTH * SPR_HEIGHT > 1) ? $clog2(SPR_WIDTH * SPR_HEIGHT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [CORDW-1:0] sprx,
  input  logic signed [CORDW-1:0] spry,
  output logic                    busy,
  output logic                    done,
  output logic [SPR_ADDRW-1:0]    spr_addr,
  input  logic [SPR_DATAW-1:0]    spr_data,
  output logic [FB_ADDRW-1:0]     fb_addr,
  output logic [SPR_DATAW-1:0]    fb_data,
  output logic                    fb_we,
  input  logic                    fb_ready
);

  localparam int BXW = (SPR_WIDTH  > 1) ? $clog2(SPR_WIDTH)  : 1;
  localparam int BYW = (SPR_HEIGHT > 1) ? $clog2(SPR_HEIGHT) : 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] READ      = 3'd1;
  localparam logic [2:0] WAIT_DATA = 3'd2;
  localparam logic [2:0] WRITE     = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  localparam logic signed [CORDW-1:0] H_LIM   = CORDW'(H_RES);
  localparam logic signed [CORDW-1:0] V_LIM   = CORDW'(V_RES);
  localparam logic [SPR_DATAW-1:0]    TRANS_V = SPR_DATAW'(TRANS_IDX);
  localparam logic [BXW-1:0]          BX_LAST = BXW'(SPR_WIDTH - 1);
  localparam logic [BYW-1:0]          BY_LAST = BYW'(SPR_HEIGHT - 1);

  logic [2:0]              state;
  logic signed [CORDW-1:0] sprx_r;
  logic signed [CORDW-1:0] spry_r;
  logic [BXW-1:0]          bx;
  logic [BYW-1:0]          by;

  logic signed [CORDW-1:0] px;
  logic signed [CORDW-1:0] py;
  logic                    visible;
  logic                    last_px;
  logic                    adv;
  logic [FB_ADDRW-1:0]     lin_addr;

  // Pixel position and visibility, evaluated while ROM data is valid (WAIT_DATA)
  always_comb begin
    px       = sprx_r + $signed({{(CORDW-BXW){1'b0}}, bx});
    py       = spry_r + $signed({{(CORDW-BYW){1'b0}}, by});
    visible  = !px[CORDW-1] && (px < H_LIM) &&
               !py[CORDW-1] && (py < V_LIM) &&
               (spr_data != TRANS_V);
    lin_addr = FB_ADDRW'(py) * FB_ADDRW'(H_RES) + FB_ADDRW'(px);
    last_px  = (bx == BX_LAST) && (by == BY_LAST);
    adv      = ((state == WAIT_DATA) && !visible) ||
               ((state == WRITE) && fb_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      fb_we    <= 1'b0;
      spr_addr <= '0;
      fb_addr  <= '0;
      fb_data  <= '0;
      bx       <= '0;
      by       <= '0;
      sprx_r   <= '0;
      spry_r   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sprx_r   <= sprx;
            spry_r   <= spry;
            bx       <= '0;
            by       <= '0;
            spr_addr <= '0;
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ:      state <= WAIT_DATA;
        WAIT_DATA: begin
          if (visible) begin
            fb_addr <= lin_addr;
            fb_data <= spr_data;
            fb_we   <= 1'b1;
            state   <= WRITE;
          end
        end
        WRITE: begin
          if (fb_ready) fb_we <= 1'b0;
        end
        DONE:      state <= IDLE;
        default:   state <= IDLE;
      endcase

      // Advance to the next bitmap pixel (overrides the state chosen above)
      if (adv) begin
        if (last_px) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end else begin
          if (bx == BX_LAST) begin
            bx <= '0;
            by <= by + BYW'(1);
          end else begin
            bx <= bx + BXW'(1);
          end
          spr_addr <= spr_addr + SPR_ADDRW'(1);
          state    <= READ;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_blit.sv
// Directed bench for sprite_blit: ROM model, framebuffer write monitor and
// per-scenario tasks with hand-derived write counts, addresses and latencies.
module tb_sprite_blit;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic signed [15:0] sprx = '0;
  logic signed [15:0] spry = '0;
  logic               busy;
  logic               done;
  logic [5:0]         spr_addr;
  logic [3:0]         spr_data = '0;
  logic [18:0]        fb_addr;
  logic [3:0]         fb_data;
  logic               fb_we;
  logic               fb_ready = 1'b1;

  logic [3:0] rom [64];
  int n_cmp = 0;
  int n_bad = 0;
  int wr_addr[$];
  int wr_data[$];
  int exp_addr[$];
  int exp_data[$];
  int we_cycles;

  sprite_blit dut (
    .clk(clk), .rst(rst), .start(start), .sprx(sprx), .spry(spry),
    .busy(busy), .done(done), .spr_addr(spr_addr), .spr_data(spr_data),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) spr_data <= rom[spr_addr];

  always @(posedge clk) begin
    if (rst && fb_we && fb_ready) begin
      wr_addr.push_back(int'(fb_addr));
      wr_data.push_back(int'(fb_data));
    end
  end

  function automatic void build_exp(input int sx, input int sy);
    exp_addr.delete();
    exp_data.delete();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        int px = sx + x;
        int py = sy + y;
        if (px >= 0 && px < 640 && py >= 0 && py < 480 && rom[y*8+x] != 4'd0) begin
          exp_addr.push_back(py * 640 + px);
          exp_data.push_back(int'(rom[y*8+x]));
        end
      end
  endfunction

  // Runs one blit; optionally stalls fb_ready on write number stall_at and
  // pulses a second start at cycle dup_at.
  task automatic run_blit(input string name, input int sx, input int sy,
                          input int exp_n, input int exp_cyc,
                          input int stall_at, input int stall_len, input int dup_at);
    int  cyc;
    int  wstarts = 0;
    int  stall_left = 0;
    logic prev_we = 1'b0;
    build_exp(sx, sy);
    @(negedge clk);
    wr_addr.delete();
    wr_data.delete();
    we_cycles = 0;
    sprx = 16'(sx);
    spry = 16'(sy);
    start = 1'b1;
    @(posedge clk);
    cyc = 1;
    #1;
    start = 1'b0;
    sprx = 16'sd123;
    spry = -16'sd77;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
    end
    while (done !== 1'b1 && cyc < 2000) begin
      if (fb_we === 1'b1) we_cycles++;
      if (stall_left > 0) begin
        n_cmp++;
        if (fb_we !== 1'b1 || fb_addr !== 19'(exp_addr[stall_at-1]) ||
            fb_data !== 4'(exp_data[stall_at-1])) begin
          n_bad++;
          $display("FAIL %s stall_hold: got we=%b addr=%0d data=%0d expected we=1 addr=%0d data=%0d",
                   name, fb_we, fb_addr, fb_data, exp_addr[stall_at-1], exp_data[stall_at-1]);
        end
        stall_left--;
        if (stall_left == 0) fb_ready = 1'b1;
      end
      if (fb_we === 1'b1 && !prev_we) begin
        wstarts++;
        if (wstarts == stall_at) begin
          fb_ready = 1'b0;
          stall_left = stall_len;
        end
      end
      prev_we = fb_we;
      if (cyc == dup_at) begin
        start = 1'b1;
        sprx = 16'sd0;
        spry = 16'sd0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      cyc++;
      #1;
    end
    start = 1'b0;
    fb_ready = 1'b1;
    n_cmp++;
    if (cyc != exp_cyc) begin
      n_bad++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, cyc, exp_cyc);
    end
    n_cmp++;
    if (wr_addr.size() != exp_n) begin
      n_bad++;
      $display("FAIL %s write_count: got %0d expected %0d", name, wr_addr.size(), exp_n);
    end
    for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
      n_cmp++;
      if (wr_addr[i] != exp_addr[i] || wr_data[i] != exp_data[i]) begin
        n_bad++;
        $display("FAIL %s write[%0d]: got addr=%0d data=%0d expected addr=%0d data=%0d",
                 name, i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy_at_done: got %b expected 0", name, busy);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done_pulse_width: got %b expected 0", name, done);
    end
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || fb_we !== 1'b0 || spr_addr !== 6'd0 ||
        fb_addr !== 19'd0 || fb_data !== 4'd0) begin
      n_bad++;
      $display("FAIL %s outputs: got busy=%b done=%b we=%b sa=%0d fa=%0d fd=%0d expected all 0",
               name, busy, done, fb_we, spr_addr, fb_addr, fb_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_start_ignored: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_opaque();
    for (int i = 0; i < 64; i++) rom[i] = 4'd5;
    run_blit("opaque", 10, 20, 64, 193, 0, 0, 0);
    n_cmp++;
    if (wr_addr.size() != 64 || wr_addr[0] != 12810 || wr_addr[63] != 17297) begin
      n_bad++;
      $display("FAIL opaque_first_last: got n=%0d expected first=12810 last=17297", wr_addr.size());
    end
  endtask

  task automatic test_clip();
    for (int i = 0; i < 64; i++) rom[i] = 4'd5;
    run_blit("clip_left", -3, 0, 40, 169, 0, 0, 0);
    n_cmp++;
    if (wr_addr.size() == 0 || wr_addr[0] != 0) begin
      n_bad++;
      $display("FAIL clip_left_first: got n=%0d expected first addr 0", wr_addr.size());
    end
    run_blit("clip_right", 636, 0, 32, 161, 0, 0, 0);
  endtask

  task automatic test_transparent();
    for (int i = 0; i < 64; i++) rom[i] = (i % 2 == 1) ? 4'(i % 16) : 4'd0;
    run_blit("transparent", 10, 20, 32, 161, 0, 0, 0);
  endtask

  task automatic test_offscreen();
    for (int i = 0; i < 64; i++) rom[i] = 4'd7;
    run_blit("offscreen", 700, -50, 0, 129, 0, 0, 0);
    n_cmp++;
    if (we_cycles != 0) begin
      n_bad++;
      $display("FAIL offscreen_we_cycles: got %0d expected 0", we_cycles);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 64; i++) rom[i] = 4'd5;
    run_blit("stall", 10, 20, 64, 198, 3, 5, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 64; i++) rom[i] = 4'(i % 16 + 1 == 16 ? 3 : i % 16 + 1);
    run_blit("start_while_busy", 100, 200, 64, 193, 0, 0, 40);
    run_blit("back_to_back", 5, 6, 64, 193, 0, 0, 0);
  endtask

  task automatic test_reset_mid_write();
    int waited = 0;
    for (int i = 0; i < 64; i++) rom[i] = 4'd9;
    @(negedge clk);
    fb_ready = 1'b0;
    sprx = 16'sd50;
    spry = 16'sd60;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (fb_we !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (fb_we !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_write_reach_write: got we=%b expected 1", fb_we);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    check_zero("reset_mid_write");
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    fb_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || fb_we !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_write_idle: got busy=%b we=%b expected 0 0", busy, fb_we);
    end
    run_blit("after_reset", 10, 20, 64, 193, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 4'd0;
    test_reset();
    test_opaque();
    test_clip();
    test_transparent();
    test_offscreen();
    test_stall();
    test_back_to_back();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_blit.md
SPRITE_BLIT -- requirements
Module: sprite_blit

Interface
REQ-001 Parameter CORDW, 16, signed coordinate width in bits.
REQ-002 Parameter H_RES, 640, framebuffer width in pixels.
REQ-003 Parameter V_RES, 480, framebuffer height in pixels.
REQ-004 Parameter SPR_WIDTH, 8, sprite bitmap width in pixels.
REQ-005 Parameter SPR_HEIGHT, 8, sprite bitmap height in pixels.
REQ-006 Parameter SPR_DATAW, 4, bits per pixel (colour index).
REQ-007 Parameter TRANS_IDX, 0, transparent colour index, never written.
REQ-008 Parameter FB_ADDRW, 19, framebuffer address width.
REQ-009 clk  in  1  clock; all logic on rising edge.
REQ-010 rst  in  1  reset, synchronous, active-low.
REQ-011 start  in  1  one-cycle request to blit sprite at sprx/spry.
REQ-012 sprx, spry  in  CORDW signed  sprite top-left framebuffer position, sampled on accepted start.
REQ-013 busy  out  1  blit in progress.
REQ-014 done  out  1  one-cycle pulse, blit complete.
REQ-015 spr_addr  out  clog2(SPR_WIDTH*SPR_HEIGHT)  sprite ROM address, row-major.
REQ-016 spr_data  in  SPR_DATAW  sprite ROM data, valid exactly one cycle after spr_addr is registered (synchronous ROM).
REQ-017 fb_addr  out  FB_ADDRW  framebuffer write address.
REQ-018 fb_data  out  SPR_DATAW  framebuffer write data.
REQ-019 fb_we  out  1  framebuffer write request.
REQ-020 fb_ready  in  1  framebuffer accepts write on a clock edge where fb_we and fb_ready are both high.

Function
REQ-021 All outputs SHALL be registered.
REQ-022 States SHALL be IDLE, READ, WAIT_DATA, WRITE, DONE.
REQ-023 IDLE: start=1 SHALL latch sprx/spry, clear bitmap counters bx=by=0, set spr_addr=0, assert busy, go READ; start while busy SHALL be ignored.
REQ-024 READ: one cycle, go WAIT_DATA (ROM latency slot).
REQ-025 WAIT_DATA: capture spr_data; px=sprx_r+bx, py=spry_r+by computed signed at CORDW; pixel visible iff 0<=px<H_RES and 0<=py<V_RES and spr_data!=TRANS_IDX.
REQ-026 Visible pixel SHALL drive fb_addr=py*H_RES+px (truncated to FB_ADDRW), fb_data=spr_data, fb_we=1, go WRITE; invisible pixel SHALL skip write and advance directly.
REQ-027 WRITE: fb_we, fb_addr, fb_data SHALL hold stable until an edge with fb_ready=1; on that edge fb_we SHALL deassert and the block advances.
REQ-028 Advance: if bx==SPR_WIDTH-1 and by==SPR_HEIGHT-1 go DONE; else bx wraps to 0 with by+1 at row end, otherwise bx+1; spr_addr+1; go READ.
REQ-029 DONE: one cycle, done=1, busy=0, go IDLE; done SHALL not assert in any other cycle.
REQ-030 Latency with fb_ready held high: one visible pixel costs 3 cycles, skipped pixel 2 cycles; 8x8 fully visible opaque sprite: done 193 cycles after start edge.
REQ-031 Pixels SHALL be written in row-major order, each at most once per blit.
REQ-032 Sprite entirely off-screen SHALL complete with zero writes and still pulse done.
REQ-033 Changes on sprx/spry during busy SHALL have no effect.

Reset
REQ-034 rst=0 at a clock edge SHALL force state IDLE, busy=0, done=0, fb_we=0, spr_addr=0, fb_addr=0, fb_data=0, bx=by=0, overriding any other action, including mid-blit and mid-write stall.
REQ-035 start coincident with rst=0 SHALL be ignored.

Verification
REQ-036 sprx=10, spry=20, all-opaque ROM (value 5), fb_ready=1 -> 64 writes, first fb_addr=12810, last 17297, data 5, done at cycle 193.
REQ-037 sprx=-3, spry=0 -> only columns bx 3..7 written (40 writes), first fb_addr=0; sprx=636 -> bx 0..3 written.
REQ-038 ROM with TRANS_IDX in even addresses -> 32 writes, odd indices only.
REQ-039 fb_ready low 5 cycles on third write -> fb_we/fb_addr/fb_data stable all 5 cycles, no write lost or duplicated.
REQ-040 sprx=700, spry=-50 -> zero fb_we cycles, done after 129 cycles.
REQ-041 rst=0 during a WRITE stall -> next cycle all outputs zero, IDLE; subsequent start blits normally; start pulse while busy -> no restart.
